// File: rtl/fetch_seq_pkg.sv
// Shared types for the fetch sequencer: register widths, ALU commands and FSM states.
package register_types;
  typedef logic [15:0] addr_t;
  typedef logic [7:0]  data_t;
endpackage

package addr_alu_types;
  typedef enum logic [1:0] {PASS, INC, DEC} cmd_t;
endpackage

package fetch_types;
  typedef enum logic [1:0] {FETCH, HOLD, FAULT} state_t;
endpackage

// File: rtl/fetch_seq_addr_alu.sv
// Address ALU: pass/increment/decrement modulo 2^16; zflag flags a carry or borrow
// out of bit 15, i.e. FFFF->0000 on INC and 0000->FFFF on DEC.
module addr_alu
  import register_types::*;
  import addr_alu_types::*;
(
  input  addr_t a,
  input  cmd_t  cmd,
  output addr_t y,
  output logic  zflag
);
  logic [16:0] sum;

  always_comb begin
    sum = {1'b0, a};
    case (cmd)
      INC:     sum = {1'b0, a} + 17'd1;
      DEC:     sum = {1'b0, a} - 17'd1;
      default: sum = {1'b0, a};
    endcase
  end

  assign y     = sum[15:0];
  assign zflag = sum[16];
endmodule

// File: rtl/fetch_seq.sv
// Fetch sequencer: one request in flight, one-entry output buffer, jump redirect.
// Define FETCH_WRAP_TRAP_EN to trap (FAULT state, wrap_fault=1) after a PC wrap.
module fetch_seq
  import register_types::*;
  import addr_alu_types::*;
  import fetch_types::*;
#(
  parameter addr_t RESET_PC = 16'h0000
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  jump_valid,
  input  addr_t jump_addr,
  output logic  mem_req,
  output addr_t mem_addr,
  input  logic  mem_ack,
  input  data_t mem_rdata,
  output logic  out_valid,
  output data_t out_data,
  output addr_t out_addr,
  input  logic  out_ready,
  output addr_t pc,
  output logic  wrap_fault
);
`ifdef FETCH_WRAP_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  state_t state;
  addr_t  pc_inc;
  logic   pc_wrap;
  logic   pend;

  addr_alu u_alu (
    .a     (pc),
    .cmd   (INC),
    .y     (pc_inc),
    .zflag (pc_wrap)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      out_data <= '0;
      out_addr <= '0;
      pend     <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          // A jump wins over a same-cycle ack: the returned word is dropped.
          if (jump_valid) begin
            pc <= jump_addr;
          end else if (mem_ack) begin
            out_data <= mem_rdata;
            out_addr <= pc;
            pc       <= pc_inc;
            pend     <= pc_wrap;
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (jump_valid) begin
            pc    <= jump_addr;
            pend  <= 1'b0;
            state <= FETCH;
          end else if (out_ready) begin
            pend  <= 1'b0;
            state <= (TRAP_EN && pend) ? FAULT : FETCH;
          end
        end
        FAULT: begin
          if (jump_valid) begin
            pc    <= jump_addr;
            pend  <= 1'b0;
            state <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  assign mem_req   = (state == FETCH);
  assign mem_addr  = pc;
  assign out_valid = (state == HOLD);

`ifdef FETCH_WRAP_TRAP_EN
  assign wrap_fault = (state == FAULT);
`else
  assign wrap_fault = 1'b0;
`endif
endmodule

// File: tb/tb_fetch_seq.sv
// Self-checking bench for fetch_seq: directed scenarios then random traffic,
// checked every cycle against a transaction-level model of the sequencer.
module tb_fetch_seq;
  import register_types::*;

`ifdef FETCH_WRAP_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  localparam int RPC = 16'h0100;

  logic  clk = 1'b0;
  logic  rst_n, jump_valid, mem_ack, out_ready;
  addr_t jump_addr;
  data_t mem_rdata;
  logic  mem_req, out_valid, wrap_fault;
  addr_t mem_addr, out_addr, pc;
  data_t out_data;

  int checks = 0;
  int fails  = 0;

  // Model: program counter, buffered word, trap status.
  int  m_pc, m_addr, m_data;
  bit  m_full, m_fault, m_pend;

  fetch_seq #(.RESET_PC(16'h0100)) dut (
    .clk(clk), .rst_n(rst_n), .jump_valid(jump_valid), .jump_addr(jump_addr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_data(out_data), .out_addr(out_addr), .out_ready(out_ready),
    .pc(pc), .wrap_fault(wrap_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RPC; m_addr = 0; m_data = 0;
    m_full = 0; m_fault = 0; m_pend = 0;
  endtask

  task automatic model_update(input logic r, input logic j, input logic [15:0] ja,
                              input logic a, input logic [7:0] d, input logic rd);
    if (!r) model_reset();
    else if (j) begin
      m_pc = ja; m_full = 0; m_fault = 0; m_pend = 0;
    end else if (m_fault) begin
    end else if (m_full) begin
      if (rd) begin
        m_full = 0;
        if (TRAP && m_pend) m_fault = 1;
        m_pend = 0;
      end
    end else if (a) begin
      m_data = d; m_addr = m_pc;
      m_pend = (m_pc == 16'hFFFF);
      m_pc   = (m_pc + 1) % 65536;
      m_full = 1;
    end
  endtask

  task automatic check_outputs();
    bit exp_req;
    exp_req = !m_full && !m_fault;
    chk("mem_req", mem_req, exp_req);
    if (exp_req) chk("mem_addr", mem_addr, 16'(m_pc));
    chk("out_valid", out_valid, m_full);
    chk("out_data", out_data, 16'(m_data));
    chk("out_addr", out_addr, 16'(m_addr));
    chk("pc", pc, 16'(m_pc));
    chk("wrap_fault", wrap_fault, m_fault);
  endtask

  // Drive one cycle of inputs, check outputs mid-cycle, advance the model at the edge.
  task automatic step(input logic r, input logic j, input logic [15:0] ja,
                      input logic a, input logic [7:0] d, input logic rd);
    rst_n = r; jump_valid = j; jump_addr = ja; mem_ack = a; mem_rdata = d; out_ready = rd;
    @(negedge clk);
    check_outputs();
    model_update(r, j, ja, a, d, rd);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 0; jump_valid = 0; jump_addr = '0; mem_ack = 1; mem_rdata = 8'hAA; out_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // Reset held with ack active: ack ignored, reset values visible.
    step(0, 0, 0, 1, 8'hAA, 1);
    step(0, 0, 0, 1, 8'hBB, 1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_req", mem_req, 1'b1);
    chk("rst_addr", mem_addr, 16'h0100);

    // Three back-to-back fetches with immediate accept.
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 1, 8'(8'h10 + i), 1);
      chk("lat_valid", out_valid, 1'b1);
      chk("lat_addr", out_addr, 16'(RPC + i));
      step(1, 0, 0, 0, 0, 1);
    end
    chk("pc_after3", pc, 16'h0103);

    // Downstream stall: buffer stable, no new request.
    step(1, 0, 0, 1, 8'h33, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 1, 8'hEE, 0);
    chk("stall_req", mem_req, 1'b0);
    chk("stall_data", out_data, 16'h0033);
    chk("stall_pc", pc, 16'h0104);
    step(1, 0, 0, 0, 0, 1);

    // Jump coincident with ack: word dropped, redirect to 2000.
    step(1, 1, 16'h2000, 1, 8'h44, 1);
    chk("jmp_addr", mem_addr, 16'h2000);
    chk("jmp_drop", out_valid, 1'b0);
    step(1, 0, 0, 0, 0, 1);

    // Jump to FFFF, fetch, accept.
    step(1, 1, 16'hFFFF, 0, 0, 1);
    step(1, 0, 0, 1, 8'h55, 0);
    chk("wrap_out_addr", out_addr, 16'hFFFF);
    chk("wrap_pc", pc, 16'h0000);
    step(1, 0, 0, 0, 0, 1);
    if (TRAP) begin
      chk("trap_fault", wrap_fault, 1'b1);
      chk("trap_req", mem_req, 1'b0);
      step(1, 0, 0, 1, 8'h66, 1);
      step(0, 0, 0, 0, 0, 1);
      chk("rst_fault_clr", wrap_fault, 1'b0);
      chk("rst_fault_pc", pc, 16'h0100);
      // Wrap again and leave FAULT via jump.
      step(1, 1, 16'hFFFF, 0, 0, 1);
      step(1, 0, 0, 1, 8'h77, 1);
      step(1, 0, 0, 0, 0, 1);
      step(1, 1, 16'h0300, 0, 0, 1);
      chk("jmp_fault_clr", wrap_fault, 1'b0);
      chk("jmp_fault_addr", mem_addr, 16'h0300);
    end else begin
      chk("nowrap_fault", wrap_fault, 1'b0);
      chk("nowrap_req", mem_req, 1'b1);
      chk("nowrap_addr", mem_addr, 16'h0000);
    end

    // Reset while holding a word.
    step(1, 0, 0, 1, 8'h88, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("rst_hold_valid", out_valid, 1'b0);
    chk("rst_hold_pc", pc, 16'h0100);
    chk("rst_hold_req", mem_req, 1'b1);
    chk("rst_hold_data", out_data, 16'h0000);

    // Random traffic.
    for (int n = 0; n < 800; n++) begin
      logic r, j, a, rd;
      logic [15:0] ja;
      int sel;
      r   = ($urandom_range(0, 99) != 0);
      j   = ($urandom_range(0, 11) == 0);
      a   = ($urandom_range(0, 1) == 1);
      rd  = ($urandom_range(0, 2) != 0);
      sel = $urandom_range(0, 3);
      ja  = (sel == 0) ? 16'hFFFF : (sel == 1) ? 16'hFFFE : 16'($urandom);
      step(r, j, ja, a, 8'($urandom), rd);
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule

// File: doc/fetch_seq.md
FETCH_SEQ -- requirements
Module: fetch_seq

Interface
REQ-001 Parameter: RESET_PC, default 16'h0000, PC value loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 jump_valid  input  1  load jump_addr into PC this cycle.
REQ-005 jump_addr  input  addr_t (16)  jump target.
REQ-006 mem_req  output  1  memory read request.
REQ-007 mem_addr  output  addr_t (16)  read address (equals pc while mem_req=1).
REQ-008 mem_ack  input  1  memory read complete; mem_rdata valid this cycle.
REQ-009 mem_rdata  input  data_t (8)  read data.
REQ-010 out_valid  output  1  fetched word available downstream.
REQ-011 out_data  output  data_t (8)  fetched word.
REQ-012 out_addr  output  addr_t (16)  address out_data was fetched from.
REQ-013 out_ready  input  1  downstream accepts word when out_valid=1.
REQ-014 pc  output  addr_t (16)  current program counter.
REQ-015 wrap_fault  output  1  PC wrapped past 16'hFFFF (see Configuration).

Function
REQ-016 States: FETCH, HOLD, FAULT; one-entry output buffer.
REQ-017 FETCH: mem_req=1, mem_addr=pc, out_valid=0; on mem_ack capture mem_rdata->out_data, pc->out_addr, pc<=pc+1, go HOLD.
REQ-018 PC increment computed only by the addr_alu sub-module with cmd INC; its zflag marks a 16'hFFFF->16'h0000 wrap.
REQ-019 Latency: mem_ack in cycle N -> out_valid=1 in cycle N+1; max throughput one word per 2 cycles.
REQ-020 HOLD: mem_req=0, out_valid=1, out_data/out_addr stable until accepted; on out_ready go FETCH (or FAULT per REQ-030).
REQ-021 jump_valid has highest priority in FETCH and HOLD: pc<=jump_addr, next state FETCH, buffer discarded, out_valid=0 next cycle.
REQ-022 jump_valid with mem_ack same cycle: fetched data dropped, no increment, pc<=jump_addr.
REQ-023 jump_valid with out_valid&out_ready same cycle: word counts as delivered, then pc<=jump_addr, FETCH.
REQ-024 Abandoned requests (mem_req drop or mem_addr change before mem_ack) are legal on the memory side.
REQ-025 PC arithmetic modulo 2^16; no other width extension.

Reset
REQ-026 rst_n=0 at a clock edge: state<=FETCH, pc<=RESET_PC, out_data<=0, out_addr<=0, wrap_fault<=0, from any state including mid-request.
REQ-027 During and the cycle after reset, out_valid=0; mem_req=1 with mem_addr=RESET_PC from the first cycle rst_n=1; mem_ack while rst_n=0 ignored.

Configuration
REQ-028 Macro FETCH_WRAP_TRAP_EN selects wrap trapping.
REQ-029 Without it: PC wraps silently to 16'h0000, fetching continues, wrap_fault tied 0, FAULT unreachable.
REQ-030 With it: a capture whose increment sets zflag sets a pending flag; after that word is accepted, go FAULT instead of FETCH.
REQ-031 FAULT: mem_req=0, out_valid=0, wrap_fault=1; exit only via rst_n=0 or jump_valid (clears wrap_fault and pending flag, go FETCH).

Structure
REQ-032 Package fetch_types holds the state enum; addr_t and data_t come from register_types; cmd_t from addr_alu_types.
REQ-033 One sub-module: addr_alu instance computing pc+1 and zflag; no other hierarchy.

Verification
REQ-034 Reset, RESET_PC=16'h0100, ack every request, out_ready=1 -> words from 0100,0101,0102 with out_valid 1 cycle after each ack.
REQ-035 out_ready=0 for 5 cycles in HOLD -> out_data/out_addr stable, mem_req=0, pc=next address, no new request.
REQ-036 jump_valid with jump_addr=16'h2000 coincident with mem_ack -> data dropped, next mem_addr=2000, no out_valid for dropped word.
REQ-037 Jump to 16'hFFFF, ack -> word at FFFF delivered; with macro wrap_fault=1 and mem_req=0 after accept; without macro next mem_addr=0000.
REQ-038 rst_n=0 in HOLD and in FAULT -> next cycle FETCH, pc=RESET_PC, out_valid=0, wrap_fault=0.
